// File: rtl/ro_fifo_reader.sv
// Readout FIFO reader: fetches one word per frame and serialises it as a
// start bit followed by the data MSB first.
module ro_fifo_reader #(
  parameter int DATA_WIDTH     = 16,
  parameter int STROBE_TIMEOUT = 4
) (
  input  logic                  BC,
  input  logic                  Reset,
  input  logic                  Empty,
  input  logic                  ROReadStrob,
  input  logic [DATA_WIDTH-1:0] FifoData,
  input  logic                  Xoff,
  output logic                  ReadEnable,
  output logic                  DataOut,
  output logic                  FrameActive,
  output logic [7:0]            WordCount,
  output logic                  ErrFlag
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_armed;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_next;
  logic [BW-1:0]         r_bit_cnt;
  logic [BW-1:0]         w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_read_en;
  logic                  w_read_en_next;
  logic                  r_data_out;
  logic                  w_data_out_next;
  logic                  r_frame;
  logic                  w_frame_next;
  logic [7:0]            r_word_cnt;
  logic [7:0]            w_word_cnt_next;
  logic                  r_err;
  logic                  w_err_next;

  // r_armed holds off the first read request until the second edge after reset.
  always_ff @(posedge BC or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_wait_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_read_en  <= 1'b0;
      r_data_out <= 1'b0;
      r_frame    <= 1'b0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_armed    <= 1'b1;
      r_wait_cnt <= w_wait_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_read_en  <= w_read_en_next;
      r_data_out <= w_data_out_next;
      r_frame    <= w_frame_next;
      r_word_cnt <= w_word_cnt_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_read_en_next  = 1'b0;
    w_data_out_next = r_data_out;
    w_frame_next    = r_frame;
    w_word_cnt_next = r_word_cnt;
    w_err_next      = r_err;

    case (r_state)
      IDLE: begin
        w_data_out_next = 1'b0;
        w_frame_next    = 1'b0;
        if (ROReadStrob) begin
          w_err_next = 1'b1;
        end
        if (r_armed && !Empty && !Xoff) begin
          w_state_next    = WAIT;
          w_read_en_next  = 1'b1;
          w_wait_cnt_next = 4'd1;
        end
      end

      WAIT: begin
        // A strobe on the timeout cycle still wins over the abort.
        if (ROReadStrob) begin
          w_shift_next    = FifoData;
          w_word_cnt_next = r_word_cnt + 8'd1;
          w_bit_cnt_next  = BW'(DATA_WIDTH);
          w_data_out_next = 1'b1;
          w_frame_next    = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = SEND;
        end else if (r_wait_cnt == 4'(STROBE_TIMEOUT)) begin
          w_err_next      = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = IDLE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 4'd1;
        end
      end

      SEND: begin
        if (ROReadStrob) begin
          w_err_next = 1'b1;
        end
        if (r_bit_cnt != '0) begin
          w_data_out_next = r_shift[DATA_WIDTH-1];
          w_shift_next    = {r_shift[DATA_WIDTH-2:0], 1'b0};
          w_bit_cnt_next  = r_bit_cnt - BW'(1);
        end else begin
          w_data_out_next = 1'b0;
          w_frame_next    = 1'b0;
          w_state_next    = IDLE;
        end
      end

      default: begin
        w_state_next    = IDLE;
        w_data_out_next = 1'b0;
        w_frame_next    = 1'b0;
      end
    endcase
  end

  assign ReadEnable  = r_read_en;
  assign DataOut     = r_data_out;
  assign FrameActive = r_frame;
  assign WordCount   = r_word_cnt;
  assign ErrFlag     = r_err;

endmodule

// File: tb/tb_ro_fifo_reader.sv
// Scoreboard bench for ro_fifo_reader: a FIFO model answers read requests,
// expected frame bits are queued at load time and checked by a monitor.
module tb_ro_fifo_reader;
  localparam int DW = 16;

  logic          BC = 1'b0;
  logic          Reset = 1'b1;
  logic          Empty = 1'b1;
  logic          ROReadStrob = 1'b0;
  logic [DW-1:0] FifoData = '0;
  logic          Xoff = 1'b0;
  logic          ReadEnable;
  logic          DataOut;
  logic          FrameActive;
  logic [7:0]    WordCount;
  logic          ErrFlag;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] fifo_q[$];
  bit            exp_q[$];
  bit            pend = 1'b0;
  bit            strobe_en = 1'b1;
  bit            stray_req = 1'b0;

  always #5 BC = ~BC;

  ro_fifo_reader #(.DATA_WIDTH(DW), .STROBE_TIMEOUT(4)) dut (
    .BC          (BC),
    .Reset       (Reset),
    .Empty       (Empty),
    .ROReadStrob (ROReadStrob),
    .FifoData    (FifoData),
    .Xoff        (Xoff),
    .ReadEnable  (ReadEnable),
    .DataOut     (DataOut),
    .FrameActive (FrameActive),
    .WordCount   (WordCount),
    .ErrFlag     (ErrFlag)
  );

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void bound_expired(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  task automatic load_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (t < budget && (exp_q.size() != 0 || fifo_q.size() != 0 || FrameActive)) begin
      @(negedge BC);
      t++;
    end
    if (t >= budget) bound_expired("drain");
    repeat (3) @(negedge BC);
  endtask

  task automatic wait_frame_start(input string name);
    int t;
    t = 0;
    while (!FrameActive && t < 60) begin
      @(negedge BC);
      t++;
    end
    if (t >= 60) bound_expired(name);
  endtask

  // FIFO model: strobe with data one cycle after a sampled read request.
  initial begin
    forever begin
      @(negedge BC);
      pend = ReadEnable && !Reset;
      @(posedge BC);
      #1;
      ROReadStrob = 1'b0;
      if (stray_req) begin
        ROReadStrob = 1'b1;
        FifoData    = 16'hDEAD;
        stray_req   = 1'b0;
      end else if (pend && strobe_en && fifo_q.size() > 0) begin
        ROReadStrob = 1'b1;
        FifoData    = fifo_q.pop_front();
      end
      pend  = 1'b0;
      Empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: every frame bit is popped from the scoreboard and compared.
  int cyc = 0;
  int re_cyc = -100;
  int flen = 0;
  int nframes = 0;
  bit prev_fa = 1'b0;
  bit prev_re = 1'b0;
  initial begin
    forever begin
      @(negedge BC);
      cyc++;
      if (Reset) begin
        flen    = 0;
        prev_fa = 1'b0;
        prev_re = 1'b0;
      end else begin
        if (ReadEnable) begin
          check("re_single_cycle", int'(prev_re), 0);
          check("re_outside_frame", int'(FrameActive), 0);
          re_cyc = cyc;
        end
        if (FrameActive) begin
          if (!prev_fa) check("start_latency", cyc - re_cyc, 2);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_bit: got DataOut=%0d with no frame expected at %0t", DataOut, $time);
          end else begin
            check("frame_bit", int'(DataOut), int'(exp_q.pop_front()));
          end
          flen++;
        end else begin
          check("idle_dataout", int'(DataOut), 0);
          if (prev_fa) begin
            nframes++;
            check("frame_len", flen, DW + 1);
            $display("frame %0d: %0d cycles, WordCount=%0d ErrFlag=%0d", nframes, flen, WordCount, ErrFlag);
            flen = 0;
          end
        end
        prev_fa = FrameActive;
        prev_re = ReadEnable;
      end
    end
  end

  initial begin
    int n;
    bit re_seen;

    // Reset state and first read request no earlier than the second edge.
    load_word(16'hA5C3);
    repeat (3) @(negedge BC);
    check("rst_readenable", int'(ReadEnable), 0);
    check("rst_dataout", int'(DataOut), 0);
    check("rst_frameactive", int'(FrameActive), 0);
    check("rst_wordcount", int'(WordCount), 0);
    check("rst_errflag", int'(ErrFlag), 0);
    #2 Reset = 1'b0;
    @(negedge BC);
    check("re_after_edge1", int'(ReadEnable), 0);
    @(negedge BC);
    check("re_after_edge2", int'(ReadEnable), 1);
    wait_drain(60);
    check("basic_wordcount", int'(WordCount), 1);

    // Back-to-back words.
    load_word(16'h0001);
    load_word(16'h8000);
    load_word(16'hFFFF);
    wait_drain(120);
    check("b2b_wordcount", int'(WordCount), 4);
    check("b2b_errflag", int'(ErrFlag), 0);

    // Xoff raised in the 5th frame cycle holds off the next word only.
    load_word(16'h3C3C);
    load_word(16'hC001);
    wait_frame_start("xoff_frame_start");
    repeat (4) @(negedge BC);
    #1 Xoff = 1'b1;
    re_seen = 1'b0;
    repeat (25) begin
      @(negedge BC);
      if (ReadEnable) re_seen = 1'b1;
    end
    check("xoff_no_re", int'(re_seen), 0);
    check("xoff_word_held", fifo_q.size(), 1);
    @(posedge BC);
    #1 Xoff = 1'b0;
    @(negedge BC);
    check("xoff_re_same_cycle", int'(ReadEnable), 0);
    @(negedge BC);
    check("xoff_re_next_cycle", int'(ReadEnable), 1);
    wait_drain(60);
    check("xoff_wordcount", int'(WordCount), 6);

    // Strobe timeout: abort after 4 WAIT cycles, retry on the following cycle.
    strobe_en = 1'b0;
    load_word(16'h1234);
    n = 0;
    while (!ReadEnable && n < 20) begin
      @(negedge BC);
      n++;
    end
    if (n >= 20) bound_expired("timeout_first_re");
    check("timeout_err_before", int'(ErrFlag), 0);
    @(posedge BC);
    #2 strobe_en = 1'b1;
    n = 0;
    do begin
      @(negedge BC);
      n++;
    end while (!ReadEnable && n < 20);
    check("timeout_retry_gap", n, 5);
    check("timeout_errflag", int'(ErrFlag), 1);
    wait_drain(60);
    check("timeout_wordcount", int'(WordCount), 7);

    // Reset in the middle of a frame.
    load_word(16'h5A5A);
    wait_frame_start("rstmid_frame_start");
    repeat (8) @(negedge BC);
    #2 Reset = 1'b1;
    #1;
    check("rstmid_dataout", int'(DataOut), 0);
    check("rstmid_frameactive", int'(FrameActive), 0);
    check("rstmid_wordcount", int'(WordCount), 0);
    check("rstmid_errflag", int'(ErrFlag), 0);
    exp_q.delete();
    repeat (2) @(negedge BC);
    #2 Reset = 1'b0;
    repeat (30) @(negedge BC);
    check("rstmid_wordcount_after", int'(WordCount), 0);

    // Stray strobe while idle.
    stray_req = 1'b1;
    repeat (4) @(negedge BC);
    check("stray_errflag", int'(ErrFlag), 1);
    check("stray_wordcount", int'(WordCount), 0);

    // WordCount wraps after 256 words.
    for (int i = 0; i < 255; i++) load_word(16'(i * 257) ^ 16'h5A3C);
    wait_drain(255 * 25);
    check("wrap_wordcount_255", int'(WordCount), 255);
    load_word(16'hFFFF);
    wait_drain(60);
    check("wrap_wordcount_0", int'(WordCount), 0);
    check("wrap_errflag_sticky", int'(ErrFlag), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ro_fifo_reader.md
RO_FIFO_READER -- requirements
Module: ro_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, readout FIFO word width in bits (min 2).
REQ-002 SHALL have parameter STROBE_TIMEOUT, default 4, the maximum number of WAIT-state cycles for ROReadStrob before abort (1..15).
REQ-003 SHALL have port BC  input  1  bunch-crossing clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Empty  input  1  readout FIFO empty flag.
REQ-006 SHALL have port ROReadStrob  input  1  FIFO read-data-valid strobe, one cycle.
REQ-007 SHALL have port FifoData  input  DATA_WIDTH  FIFO read data, valid only while ROReadStrob=1.
REQ-008 SHALL have port Xoff  input  1  downstream hold; blocks the start of new frames only.
REQ-009 SHALL have port ReadEnable  output  1  registered one-cycle FIFO read request.
REQ-010 SHALL have port DataOut  output  1  registered serial frame output.
REQ-011 SHALL have port FrameActive  output  1  high on every cycle DataOut carries a frame bit.
REQ-012 SHALL have port WordCount  output  8  count of words captured, modulo 256.
REQ-013 SHALL have port ErrFlag  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement the states IDLE, WAIT and SEND.
REQ-015 In IDLE with Empty=0 and Xoff=0, the block SHALL go to WAIT and drive ReadEnable=1 for exactly the next cycle.
REQ-016 In IDLE with Empty=1 or Xoff=1, the block SHALL stay in IDLE with ReadEnable=0.
REQ-017 In WAIT, ReadEnable SHALL be 0, and a WAIT cycle counter SHALL count cycles from 1 upward.
REQ-018 In WAIT with ROReadStrob=1, the block SHALL capture FifoData into the shift register, increment WordCount (wrapping 255->0) and go to SEND.
REQ-019 In WAIT, when the counter reaches STROBE_TIMEOUT with no strobe, the block SHALL set ErrFlag, return to IDLE and discard nothing.
REQ-020 A frame SHALL be 1+DATA_WIDTH consecutive cycles: a start bit of 1, then the data bits MSB first.
REQ-021 FrameActive SHALL be 1 for exactly those 1+DATA_WIDTH cycles.
REQ-022 After the last data bit, the block SHALL go to IDLE; at least one IDLE cycle SHALL separate frames.
REQ-023 Outside frames, DataOut SHALL be 0 and FrameActive SHALL be 0.
REQ-024 Xoff asserted during WAIT or SEND SHALL NOT pause or truncate the frame in progress.
REQ-025 Empty rising during WAIT SHALL be ignored; the outstanding strobe is still awaited.
REQ-026 ROReadStrob=1 in IDLE or SEND SHALL set ErrFlag, and the data SHALL be ignored.
REQ-027 ErrFlag SHALL be cleared only by Reset.
REQ-028 Latency SHALL be as follows, with the IDLE->WAIT edge at cycle k and the FIFO strobe at cycle k+2:
  - ReadEnable high in cycle k+1;
  - start bit in cycle k+3;
  - data bit DATA_WIDTH-1-i in cycle k+4+i;
  - back to IDLE in cycle k+4+DATA_WIDTH.
REQ-029 If ROReadStrob and the timeout condition coincide, the strobe SHALL take priority and no error SHALL be flagged.

Reset
REQ-030 Reset=1 SHALL immediately force the following, independent of BC:
  - state IDLE;
  - ReadEnable=0, DataOut=0, FrameActive=0;
  - WordCount=0, ErrFlag=0;
  - shift register and counters cleared.
REQ-031 Reset asserted mid-frame SHALL abort the frame, and the word SHALL NOT be re-sent after release.
REQ-032 After Reset deasserts, the first ReadEnable SHALL occur no earlier than the second rising edge.

Verification
REQ-033 Basic frame: Empty=0, Xoff=0, FIFO returns strobe one cycle after ReadEnable with FifoData=16'hA5C3 -> DataOut 1,1010010111000011 over 17 cycles, FrameActive high for 17 cycles, WordCount=1.
REQ-034 Back-to-back: FIFO holds 3 words 0001, 8000, FFFF -> 3 frames, each preceded by one ReadEnable pulse and separated by at least one idle cycle; WordCount=3, ErrFlag=0.
REQ-035 Timeout: ReadEnable issued, no strobe for 4 cycles -> ErrFlag=1, state IDLE, no FrameActive; with Empty=0 a new ReadEnable follows on the next cycle.
REQ-036 Xoff: Xoff=1 asserted in the 5th cycle of a frame -> frame completes all 17 bits; no ReadEnable while Xoff=1; ReadEnable on the cycle after Xoff falls.
REQ-037 Stray strobe and wrap: ROReadStrob pulsed in IDLE -> ErrFlag=1, no frame; 256 frames -> WordCount returns to 0.
REQ-038 Reset mid-frame: Reset pulsed at bit 8 -> DataOut=0, FrameActive=0 immediately; WordCount=0 and no residual bits after release.
